// File: rtl/zintack_pkg.sv
// zintack shared definitions: Z80 opcode bytes the decoder recognises and
// the RETI/RETN decode FSM state encoding.
package zintack_pkg;

    localparam logic [7:0] OP_ED   = 8'hED;
    localparam logic [7:0] OP_RETI = 8'h4D;
    localparam logic [7:0] OP_RETN = 8'h45;
    localparam logic [7:0] OP_DD   = 8'hDD;
    localparam logic [7:0] OP_FD   = 8'hFD;

    typedef enum logic {
        IDLE = 1'b0,
        ED   = 1'b1
    } dec_state_t;

endpackage

// File: rtl/zintack_fetch.sv
// zintack_fetch: Z80 bus front end. Registers the INTA condition into the
// intack level and turns the trailing edge of an M1 memory read into a
// one-clk fetch strobe with the latched opcode byte.
module zintack_fetch (
    input  logic       clk,
    input  logic       res,
    input  logic       m1_n,
    input  logic       iorq_n,
    input  logic       mreq_n,
    input  logic [7:0] di,
    output logic       intack,
    output logic [7:0] op,
    output logic       fetch
);

    logic mreq_q;
    logic fetch_edge;

    // An opcode fetch ends when /MREQ rises during M1 with /IORQ idle;
    // INTA cycles keep /IORQ low, so they can never look like a fetch.
    assign fetch_edge = mreq_n & ~mreq_q & ~m1_n & iorq_n;

    // Register the INTA condition, the previous /MREQ level and the opcode.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            intack <= 1'b0;
            mreq_q <= 1'b1;
            op     <= 8'h00;
            fetch  <= 1'b0;
        end else begin
            intack <= ~m1_n & ~iorq_n;
            mreq_q <= mreq_n;
            fetch  <= fetch_edge;
            if (fetch_edge) begin
                op <= di;
            end
        end
    end

endmodule

// File: rtl/zintack.sv
// zintack: CPU-side interrupt acknowledge unit. Produces intack, supplies
// the IM2 vector during INTA, decodes RETI/RETN and tracks nesting depth.
// Optional feature macro: ZINTACK_RETN_EN (RETN strobe and nest decrement).
module zintack
    import zintack_pkg::*;
#(
    parameter int NEST_W   = 3,
    parameter int VECT_DLY = 2
) (
    input  logic              clk,
    input  logic              res,
    input  logic              m1_n,
    input  logic              iorq_n,
    input  logic              mreq_n,
    input  logic [7:0]        di,
    input  logic [7:0]        im2vect,
    output logic              intack,
    output logic              vect_oe,
    output logic [7:0]        dout,
    output logic              reti,
    output logic              retn,
    output logic [NEST_W-1:0] nest,
    output logic              in_isr
);

    localparam logic [2:0]        CAP_AT   = 3'(VECT_DLY - 1);
    localparam logic [NEST_W-1:0] NEST_MAX = '1;

    logic [7:0]  op;
    logic        fetch;
    logic        intack_d;
    logic        intack_fall;
    logic [2:0]  dly_cnt;
    logic        vect_q;
    logic        reti_c;
    logic        retn_c;
    logic        nest_inc;
    logic        nest_dec;
    dec_state_t  state;
    dec_state_t  state_nxt;

    zintack_fetch u_fetch (
        .clk    (clk),
        .res    (res),
        .m1_n   (m1_n),
        .iorq_n (iorq_n),
        .mreq_n (mreq_n),
        .di     (di),
        .intack (intack),
        .op     (op),
        .fetch  (fetch)
    );

    // Delayed intack for rise/fall detection.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            intack_d <= 1'b0;
        end else begin
            intack_d <= intack;
        end
    end

    assign intack_fall = intack_d & ~intack;

    // Count clks of intack high and capture the vector once the
    // controller's vector-select latch has settled.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            dly_cnt <= 3'd0;
            vect_q  <= 1'b0;
            dout    <= 8'h00;
        end else if (!intack) begin
            dly_cnt <= 3'd0;
            vect_q  <= 1'b0;
        end else if (!vect_q) begin
            if (dly_cnt == CAP_AT) begin
                vect_q <= 1'b1;
                dout   <= im2vect;
            end else begin
                dly_cnt <= dly_cnt + 3'd1;
            end
        end
    end

    // Gating with intack releases the bus the same clk intack drops.
    assign vect_oe = vect_q & intack;

    // Decode FSM state register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and return strobes, advanced by opcode fetches only.
    always_comb begin
        state_nxt = state;
        reti_c    = 1'b0;
        retn_c    = 1'b0;
        if (fetch) begin
            case (state)
                IDLE: begin
                    state_nxt = (op == OP_ED) ? ED : IDLE;
                end
                ED: begin
                    if (op == OP_RETI) begin
                        reti_c    = 1'b1;
                        state_nxt = IDLE;
                    end else if (op == OP_RETN) begin
`ifdef ZINTACK_RETN_EN
                        retn_c    = 1'b1;
`endif
                        state_nxt = IDLE;
                    end else if (op == OP_ED) begin
                        state_nxt = ED;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign reti     = reti_c;
    assign retn     = retn_c;
    assign nest_inc = intack_fall & vect_q;
    assign nest_dec = reti_c | retn_c;

    // Saturating nesting counter; simultaneous entry and return cancel.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            nest <= '0;
        end else if (nest_inc && !nest_dec) begin
            if (nest != NEST_MAX) begin
                nest <= nest + 1'b1;
            end
        end else if (nest_dec && !nest_inc) begin
            if (nest != '0) begin
                nest <= nest - 1'b1;
            end
        end
    end

    assign in_isr = (nest != '0);

endmodule

// File: doc/zintack.md
Name: zintack

Overview:
- CPU-side counterpart of the ~INT generator.
- Watches the Z80 bus for interrupt-acknowledge (INTA) cycles and produces the `intack` level that the interrupt controller edge-detects.
- Captures the controller's IM2 vector and drives it onto the CPU data bus during INTA.
- Decodes RETI/RETN opcode fetches and tracks interrupt nesting depth for status and debug readback.

Parameters:
- NEST_W, 3, width of the in-service nesting counter; saturates at 2^NEST_W-1.
- VECT_DLY, 2, clk cycles from `intack` rise to vector capture; covers the controller's vector-select latch latency; legal range 1..4.

Ports:
- clk  in  1  system clock
- res  in  1  asynchronous active-high reset
- m1_n  in  1  Z80 /M1, already synchronous to clk
- iorq_n  in  1  Z80 /IORQ
- mreq_n  in  1  Z80 /MREQ
- di  in  8  CPU data bus as seen during opcode fetch
- im2vect  in  8  vector from the interrupt controller
- intack  out  1  high while an INTA cycle is in progress
- vect_oe  out  1  data-bus drive enable for the vector
- dout  out  8  vector driven when vect_oe=1
- reti  out  1  one-clk strobe on a decoded RETI (ED 4D)
- retn  out  1  one-clk strobe on a decoded RETN (ED 45)
- nest  out  NEST_W  current interrupt nesting depth
- in_isr  out  1  high when nest != 0

Behaviour:
- Reset: all of the following are 0 and the FSM is in IDLE.
  - Outputs: intack, vect_oe, dout, reti, retn, nest.
  - Internal state: fetch latch, delay counter.
  - Reset mid-INTA drops vect_oe the same cycle it asserts.
- INTA detect:
  - inta_raw = !m1_n && !iorq_n, registered once.
  - intack = the registered value, so latency is 1 clk from the bus condition.
  - intack deasserts 1 clk after iorq_n or m1_n goes high.
- Vector capture:
  - A counter starts on intack rise.
  - At VECT_DLY clks, dout <= im2vect and vect_oe <= 1.
  - vect_oe clears on intack fall; dout holds its value.
  - If intack falls before VECT_DLY, no capture happens and nest is not incremented (aborted cycle).
- Opcode fetch capture:
  - On the clk where mreq_n rises while m1_n=0 and iorq_n=1, latch di as `op` and pulse `fetch` for one clk.
  - INTA cycles never generate `fetch`.
- Decode FSM, acting on `fetch` only:
  - IDLE: op=ED -> ED; any other op -> IDLE. DD/FD prefixes stay in IDLE, so a following ED still decodes.
  - ED: op=4D -> pulse reti, go to IDLE. op=45 -> pulse retn (feature-gated), go to IDLE. op=ED -> stay in ED. Anything else -> IDLE.
  - Non-M1 reads (displacements, operands) never advance the FSM.
- Nesting counter:
  - +1 on the clk intack falls after a completed capture.
  - -1 on reti.
  - Saturates at max and at 0; a RETI at nest=0 leaves it 0.
  - If increment and decrement fall on the same clk, nest is unchanged.
- in_isr is combinational from nest.

Optional Feature:
- ZINTACK_RETN_EN
  - Defined: ED 45 pulses retn and also decrements nest with the same saturation rules as RETI.
  - Undefined: retn is tied 0. ED 45 returns the FSM to IDLE without any effect; nest changes only via RETI.

Decomposition:
- Shared package / include:
  - Opcode constants: OP_ED=8'hED, OP_RETI=8'h4D, OP_RETN=8'h45, OP_DD=8'hDD, OP_FD=8'hFD.
  - FSM state encodings: IDLE and ED.
- Sub-module zintack_fetch:
  - Bus edge detection, intack register, `op`/`fetch` generation.
  - The top level holds the decode FSM, vector capture and nest counter.

Test Plan:
- INTA: m1_n=0 and iorq_n=0 for 6 clks with im2vect=FD -> intack high 1 clk later; after 2 further clks vect_oe=1, dout=FD; both vect_oe and intack clear 1 clk after release; nest=1.
- RETI: fetches ED then 4D with nest=1 -> reti pulses for exactly 1 clk after the second fetch; nest=0; in_isr=0.
- Prefixed sequences:
  - Fetches DD, ED, 4D -> reti pulses.
  - Fetches ED, then a memory read of 4D (m1_n=1), then fetch 00 -> no reti pulse.
- Saturation:
  - 9 completed INTAs with NEST_W=3 -> nest stays at 7.
  - RETI at nest=0 -> nest stays 0.
- Aborted INTA: iorq_n low for 1 clk only -> vect_oe never asserts and nest is unchanged.
- RETN:
  - Fetches ED, 45 at nest=2 with the feature defined -> retn pulses, nest=1.
  - Same stimulus with the feature undefined -> retn=0, nest stays 2.
- Reset: res asserted mid-INTA with vect_oe=1 -> vect_oe, intack and nest go to 0 immediately, without waiting for a clk edge.
